// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use/branch/HI-LO stalls and HI/LO busy tracker for a 5-stage MIPS pipe.
// Latency: forward/stall/flush are combinational; md_busy/md_done are registered (busy from the cycle after mdstart_e).
// Backpressure: stall_f/stall_d hold fetch/decode and flush_e bubbles E; optional HAZARD_STATS_EN adds stall_count.
module hazard_ctrl #(
  parameter int MD_CYCLES = 8,  // cycles a mult/div occupies HI/LO, 1..64
  parameter int CW        = 6   // busy counter width, 2^CW > MD_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] writereg_e,
  input  logic [4:0] writereg_m,
  input  logic [4:0] writereg_w,
  input  logic       regwrite_e,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  input  logic       memtoreg_e,
  input  logic       memtoreg_m,
  input  logic       branch_d,
  input  logic       md_d,
  input  logic       mdstart_e,
  output logic [1:0] forward_ae,
  output logic [1:0] forward_be,
  output logic       forward_ad,
  output logic       forward_bd,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       md_busy,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_count,
`endif
  output logic       md_done
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t     state;
  logic [CW-1:0] cnt;

  // Writers to $0 never produce a usable value, so they are masked here once.
  logic wr_e_ok, wr_m_ok, wr_w_ok;
  logic lwstall, branchstall, mdstall, stall;

  assign wr_e_ok = regwrite_e && (writereg_e != 5'd0);
  assign wr_m_ok = regwrite_m && (writereg_m != 5'd0);
  assign wr_w_ok = regwrite_w && (writereg_w != 5'd0);

  // E-stage operand selects: M beats W so the youngest value wins.
  always_comb begin
    forward_ae = 2'd0;
    forward_be = 2'd0;
    if (wr_m_ok && (writereg_m == rs_e))      forward_ae = 2'd2;
    else if (wr_w_ok && (writereg_w == rs_e)) forward_ae = 2'd1;
    if (wr_m_ok && (writereg_m == rt_e))      forward_be = 2'd2;
    else if (wr_w_ok && (writereg_w == rt_e)) forward_be = 2'd1;
  end

  assign forward_ad = wr_m_ok && (writereg_m == rs_d);
  assign forward_bd = wr_m_ok && (writereg_m == rt_d);

  // A load in E cannot forward in time for a D consumer.
  assign lwstall = memtoreg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));

  // Branch compares in D: an ALU result still in E, or a load still in M, is not yet forwardable.
  assign branchstall = branch_d &&
      ((wr_e_ok && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
       (memtoreg_m && (writereg_m != 5'd0) && ((writereg_m == rs_d) || (writereg_m == rt_d))));

  assign mdstall = md_busy && md_d;
  assign stall   = lwstall || branchstall || mdstall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  // HI/LO occupancy FSM; md_done is registered one cycle early so it lines up with the last BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else if (state == IDLE) begin
      md_done <= 1'b0;
      if (mdstart_e) begin
        state   <= BUSY;
        cnt     <= CW'(MD_CYCLES - 1);
        md_busy <= 1'b1;
        md_done <= (MD_CYCLES == 1);
      end
    end else begin
      // mdstart_e is ignored here; mdstall keeps a second op parked in D.
      if (cnt == '0) begin
        state   <= IDLE;
        md_busy <= 1'b0;
        md_done <= 1'b0;
      end else begin
        cnt     <= cnt - CW'(1);
        md_done <= (cnt == CW'(1));
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating count of stalled decode cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'd0;
    end else if (stall_d && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MD_CYCLES = 8).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Define HAZARD_STATS_EN to also exercise stall_count.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
  logic       branch_d, md_d, mdstart_e;
  logic [1:0] forward_ae, forward_be;
  logic       forward_ad, forward_bd, stall_f, stall_d, flush_e, md_busy, md_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [8:0]  sb_comb[$];
  logic [2:0]  sb_md[$];
  logic [8:0]  exp_c;
  logic [2:0]  exp_m;
  logic [8:0]  obs_c;
  logic [2:0]  obs_m;

  assign obs_c = {forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d, flush_e};
  assign obs_m = {md_busy, md_done, stall_d};

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(8), .CW(6)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .branch_d(branch_d), .md_d(md_d), .mdstart_e(mdstart_e),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .md_busy(md_busy),
`ifdef HAZARD_STATS_EN
    .stall_count(stall_count),
`endif
    .md_done(md_done)
  );

  function automatic logic [8:0] mk(input logic [1:0] fae, input logic [1:0] fbe,
                                    input logic fad, input logic fbd, input logic st);
    return {fae, fbe, fad, fbd, st, st, st};
  endfunction

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memtoreg_m = 0; branch_d = 0; md_d = 0; mdstart_e = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    sb_md.push_back(3'b000);
    sb_comb.push_back(mk(2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    #1;
    exp_m = sb_md.pop_front();
    checks++;
    if (obs_m !== exp_m) begin
      errors++; $display("FAIL reset_md: got %b want %b", obs_m, exp_m);
    end
    exp_c = sb_comb.pop_front();
    checks++;
    if (obs_c !== exp_c) begin
      errors++; $display("FAIL reset_comb: got %b want %b", obs_c, exp_c);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d want 0", stall_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_forward_e();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin rs_e = 5; rt_e = 5; regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 5;
                 sb_comb.push_back(mk(2'd2, 2'd2, 0, 0, 0)); end
        1: begin rs_e = 5; rt_e = 5; regwrite_m = 0; writereg_m = 5; regwrite_w = 1; writereg_w = 5;
                 sb_comb.push_back(mk(2'd1, 2'd1, 0, 0, 0)); end
        2: begin rs_e = 0; rt_e = 0; regwrite_m = 0; writereg_m = 5; regwrite_w = 1; writereg_w = 0;
                 sb_comb.push_back(mk(2'd0, 2'd0, 0, 0, 0)); end
        3: begin rs_e = 5; rt_e = 7; regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 7;
                 sb_comb.push_back(mk(2'd2, 2'd1, 0, 0, 0)); end
        4: begin rs_e = 0; rt_e = 0; regwrite_m = 1; writereg_m = 0; regwrite_w = 1; writereg_w = 0;
                 sb_comb.push_back(mk(2'd0, 2'd0, 0, 0, 0)); end
        default: begin rs_e = 9; rt_e = 9; regwrite_m = 1; writereg_m = 5; regwrite_w = 1; writereg_w = 7;
                 sb_comb.push_back(mk(2'd0, 2'd0, 0, 0, 0)); end
      endcase
      #1;
      exp_c = sb_comb.pop_front();
      checks++;
      if (obs_c !== exp_c) begin
        errors++; $display("FAIL fwd_e[%0d]: got %b want %b", i, obs_c, exp_c);
      end
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin memtoreg_e = 1; rt_e = 8; rs_d = 8; rt_d = 0; sb_comb.push_back(mk(0, 0, 0, 0, 1)); end
        1: begin memtoreg_e = 1; rt_e = 9; rs_d = 8; rt_d = 3; sb_comb.push_back(mk(0, 0, 0, 0, 0)); end
        2: begin memtoreg_e = 1; rt_e = 9; rs_d = 1; rt_d = 9; sb_comb.push_back(mk(0, 0, 0, 0, 1)); end
        3: begin memtoreg_e = 1; rt_e = 0; rs_d = 0; rt_d = 0; sb_comb.push_back(mk(0, 0, 0, 0, 0)); end
        default: begin memtoreg_e = 0; rt_e = 8; rs_d = 8; sb_comb.push_back(mk(0, 0, 0, 0, 0)); end
      endcase
      #1;
      exp_c = sb_comb.pop_front();
      checks++;
      if (obs_c !== exp_c) begin
        errors++; $display("FAIL load_use[%0d]: got %b want %b", i, obs_c, exp_c);
      end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin branch_d = 1; rs_d = 3; regwrite_e = 1; writereg_e = 3; sb_comb.push_back(mk(0, 0, 0, 0, 1)); end
        1: begin branch_d = 1; rs_d = 3; memtoreg_m = 1; writereg_m = 3; sb_comb.push_back(mk(0, 0, 0, 0, 1)); end
        2: begin branch_d = 1; rs_d = 3; regwrite_m = 1; writereg_m = 3; sb_comb.push_back(mk(0, 0, 1, 0, 0)); end
        3: begin branch_d = 0; rs_d = 3; regwrite_e = 1; writereg_e = 3; sb_comb.push_back(mk(0, 0, 0, 0, 0)); end
        4: begin branch_d = 1; rs_d = 0; rt_d = 0; regwrite_e = 1; writereg_e = 0; sb_comb.push_back(mk(0, 0, 0, 0, 0)); end
        5: begin branch_d = 1; rs_d = 4; rt_d = 6; regwrite_m = 1; writereg_m = 6; sb_comb.push_back(mk(0, 0, 0, 1, 0)); end
        default: begin branch_d = 1; rs_d = 4; rt_d = 6; regwrite_e = 1; writereg_e = 6;
                       memtoreg_e = 1; rt_e = 4; sb_comb.push_back(mk(0, 0, 0, 0, 1)); end
      endcase
      #1;
      exp_c = sb_comb.pop_front();
      checks++;
      if (obs_c !== exp_c) begin
        errors++; $display("FAIL branch[%0d]: got %b want %b", i, obs_c, exp_c);
      end
    end
  endtask

  task automatic test_mult_div();
    @(negedge clk);
    clear_inputs();
    mdstart_e = 1; md_d = 1;
    sb_md.push_back(3'b000);
    #1;
    exp_m = sb_md.pop_front();
    checks++;
    if (obs_m !== exp_m) begin
      errors++; $display("FAIL md_start: got %b want %b", obs_m, exp_m);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mdstart_e = 0;
      sb_md.push_back({(i < 8) ? 1'b1 : 1'b0, (i == 7) ? 1'b1 : 1'b0, (i < 8) ? 1'b1 : 1'b0});
      #1;
      exp_m = sb_md.pop_front();
      checks++;
      if (obs_m !== exp_m) begin
        errors++; $display("FAIL md_cycle[%0d]: got busy/done/stall %b want %b", i, obs_m, exp_m);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    clear_inputs();
    mdstart_e = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mdstart_e = 0;
      sb_md.push_back(3'b100);
      #1;
      exp_m = sb_md.pop_front();
      checks++;
      if (obs_m !== exp_m) begin
        errors++; $display("FAIL rst_busy_pre[%0d]: got %b want %b", i, obs_m, exp_m);
      end
      if (i == 2) reset = 1'b1;
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      reset = 1'b0;
      sb_md.push_back(3'b000);
      #1;
      exp_m = sb_md.pop_front();
      checks++;
      if (obs_m !== exp_m) begin
        errors++; $display("FAIL rst_busy_post[%0d]: got %b want %b", j, obs_m, exp_m);
      end
    end
    test_mult_div();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      memtoreg_e = 1; rt_e = 8; rs_d = 8;
    end
    @(negedge clk);
    clear_inputs();
    mdstart_e = 1; md_d = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mdstart_e = 0;
    end
    md_d = 0;
    #1;
    checks++;
    if (stall_count !== 32'd13) begin
      errors++; $display("FAIL stats_count: got %0d want 13", stall_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL stats_reset: got %0d want 0", stall_count);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forward_e();
    test_load_use();
    test_branch();
    test_mult_div();
    test_reset_busy();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipelined MIPS datapath. It drives the 2-bit selects of the E-stage 3-input operand muxes and the D-stage branch-compare forwarding. It generates stall/flush for load-use and branch hazards. A sequential busy tracker for the multicycle multiply/divide unit stalls D-stage mult/div/mfhi/mflo until the HI/LO results are ready.

Parameters:
MD_CYCLES, 8, number of cycles a mult/div occupies the HI/LO unit; legal range 1..64
CW, 6, width of the internal busy counter; must satisfy 2^CW > MD_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
rs_d, rt_d  input  5 each  source register numbers in D
rs_e, rt_e  input  5 each  source register numbers in E
writereg_e, writereg_m, writereg_w  input  5 each  destination register in E/M/W
regwrite_e, regwrite_m, regwrite_w  input  1 each  stage writes register file
memtoreg_e, memtoreg_m  input  1 each  stage holds a load
branch_d  input  1  D holds a branch that compares in D
md_d  input  1  D holds mult/div/mfhi/mflo
mdstart_e  input  1  E holds mult/div; starts HI/LO unit
forward_ae, forward_be  output  2 each  E operand mux selects: 0 = regfile, 1 = result_w, 2 = aluout_m; 3 never driven
forward_ad, forward_bd  output  1 each  D compare operand takes aluout_m
stall_f, stall_d  output  1 each  hold PC / IF-ID register
flush_e  output  1  clear ID-EX register
md_busy  output  1  HI/LO unit occupied
md_done  output  1  one-cycle pulse; HI/LO write enable

Behaviour:
- Register $0 never matches in any comparison; writereg == 0 causes neither forwarding nor stalls.
- forward_ae:
  - 2 if regwrite_m and writereg_m == rs_e.
  - Else 1 if regwrite_w and writereg_w == rs_e.
  - Else 0.
  - M has priority over W when both match.
- forward_be: same rule using rt_e.
- forward_ad = regwrite_m and writereg_m == rs_d. forward_bd uses rt_d.
- lwstall = memtoreg_e and rt_e != 0 and (rt_e == rs_d or rt_e == rt_d).
- branchstall = branch_d and one of:
  - regwrite_e and writereg_e matches rs_d or rt_d, or
  - memtoreg_m and writereg_m matches rs_d or rt_d.
- mdstall = md_busy and md_d.
- stall_f = stall_d = flush_e = lwstall | branchstall | mdstall.
- All forward/stall/flush outputs are combinational from the current-cycle inputs and md_busy; no registered latency.
- HI/LO FSM has two states, IDLE and BUSY, plus counter cnt[CW-1:0]:
  - IDLE: on mdstart_e, go to BUSY with cnt = MD_CYCLES-1. Otherwise stay.
  - BUSY: if cnt == 0, go to IDLE and assert md_done this cycle. Else decrement cnt.
  - mdstart_e while BUSY is ignored. It cannot legally occur because mdstall holds the op in D.
  - md_busy = (state == BUSY). It first asserts the cycle after mdstart_e and lasts exactly MD_CYCLES cycles.
  - md_done is high only in the final BUSY cycle. With MD_CYCLES = 1, BUSY lasts one cycle and md_done is high in it.
  - md_busy deasserts the cycle after md_done, so a waiting D-stage md op proceeds then.
- Reset (sync, high):
  - state = IDLE, cnt = 0, md_busy = 0, md_done = 0.
  - Combinational outputs follow their inputs; with md_busy = 0, mdstall = 0.
- Reset asserted during BUSY aborts the operation: IDLE next cycle, no md_done pulse.
- Simultaneous hazards: stall is the OR of all sources; forwarding selects are unaffected by stall.

Optional Feature:
HAZARD_STATS_EN:
- When defined, adds output stall_count[31:0]. It increments on every clock where stall_d = 1 and reset = 0, saturates at 32'hFFFF_FFFF, and is cleared to 0 by reset.
- When undefined, the port and the counter do not exist and behaviour is otherwise identical.

Test Plan:
- E-stage forwarding: rs_e = rt_e = 5, regwrite_m = 1, writereg_m = 5, regwrite_w = 1, writereg_w = 5 -> forward_ae = forward_be = 2. Then regwrite_m = 0 -> both = 1. Then writereg_w = 0 with rs_e = rt_e = 0 -> both = 0.
- Load-use stall: memtoreg_e = 1, rt_e = 8, rs_d = 8 -> stall_f = stall_d = flush_e = 1 for that cycle. Then rt_e = 9 with rs_d = 8, rt_d != 9 -> all 0.
- Branch stall:
  - branch_d = 1, rs_d = 3, regwrite_e = 1, writereg_e = 3 -> stall = 1.
  - Next case: memtoreg_m = 1, writereg_m = 3 -> stall = 1.
  - Next case: regwrite_m = 1 without memtoreg_m -> stall = 0 and forward_ad = 1.
- Mult/div with MD_CYCLES = 8: pulse mdstart_e at cycle T -> md_busy high T+1..T+8, md_done high only at T+8. md_d = 1 throughout -> stall_d high T+1..T+8 and low at T+9.
- Reset mid-BUSY: start a mult/div, assert reset at busy cycle 3 -> md_busy = 0 next cycle, md_done never pulses, and a new mdstart_e afterwards gives a full 8-cycle busy.
- With HAZARD_STATS_EN: 5 load-use stall cycles plus 8 mdstall cycles -> stall_count = 13. Reset -> 0.
